aes_enc_core: RTL and testbench
===============================

// Module: aes_enc_core
// PURPOSE
//  Iterative AES encryption engine, the forward-direction counterpart of the decrypt datapath.
//  Per round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey; MixColumns skipped in the final round.
//  Runs one round per clock and takes round keys from an external key-schedule block by index.
//  Sits between the input block buffer and the output/ciphertext FIFO, with valid/ready on both sides.
// PARAMETERS
//  NUM_ROUNDS  10   rounds per block; legal values 10/12/14 (AES-128/192/256).
//  RKIDX_W     4    width of round-key index; must satisfy 2**RKIDX_W > NUM_ROUNDS.
// PORTS
//  clk         in   1        system clock, rising edge
//  n_rst       in   1        asynchronous reset, active-low
//  i_valid     in   1        plaintext block valid
//  o_ready     out  1        core can accept a block (high only in IDLE)
//  i_data      in   128      plaintext; byte0 = [127:120]; state s[r][c] = byte(4c+r)
//  o_rk_idx    out  RKIDX_W  round-key index requested, 0..NUM_ROUNDS
//  i_rk_data   in   128      round key for o_rk_idx; combinational, valid in the same cycle
//  o_valid     out  1        ciphertext valid
//  i_ready     in   1        downstream accepts ciphertext
//  o_data      out  128      ciphertext, same byte ordering as i_data
//  o_busy      out  1        high from block accept until ciphertext handshake completes
// BEHAVIOUR
//  Reset values: state reg = 0, round counter = 0, FSM = IDLE.
//   Outputs on reset: o_ready = 1, o_valid = 0, o_busy = 0, o_data = 0, o_rk_idx = 0.
//  FSM states: IDLE, ROUND, FINAL, DONE.
//  IDLE:
//   o_rk_idx = 0.
//   On i_valid && o_ready: state <= i_data ^ i_rk_data, rnd <= 1, go to ROUND.
//   (If NUM_ROUNDS == 1, which is illegal, the FSM goes to FINAL instead.)
//  ROUND:
//   o_rk_idx = rnd.
//   state <= MixColumns(ShiftRows(SubBytes(state))) ^ i_rk_data.
//   rnd increments; when rnd == NUM_ROUNDS-1 the FSM goes to FINAL.
//  FINAL:
//   o_rk_idx = NUM_ROUNDS.
//   state <= ShiftRows(SubBytes(state)) ^ i_rk_data.
//   Go to DONE.
//  DONE:
//   o_valid = 1; o_data = state, held stable while i_ready is low.
//   On i_ready: return to IDLE, o_valid drops the next cycle.
//  Latency: NUM_ROUNDS+1 clocks from accept to first o_valid (11 for AES-128).
//   Throughput: one block per NUM_ROUNDS+2 clocks when i_ready is tied high.
//  o_rk_idx is registered (driven from rnd and the FSM state).
//   Round-key data is sampled only in the cycle its index is presented.
//  ShiftRows: out s[r][c] = in s[r][(c+r) mod 4]. Row 0 is unchanged; row r rotates left by r.
//  MixColumns: GF(2^8) with polynomial x^8+x^4+x^3+x+1; xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
//  i_valid while busy: ignored (o_ready = 0). i_data may change freely outside the accept cycle.
//  i_ready high with o_valid low: ignored.
//  Reset asserted mid-block: the block is aborted and no partial result is ever presented.
//  An o_valid/i_ready handshake in DONE and a new i_valid cannot overlap: the core accepts again one cycle later, in IDLE.
// STRUCTURE
//  Package aes_pkg holds:
//   state_t (128-bit), the fsm_t enum, the SBOX[256] constant table,
//   functions xtime, shift_rows_f, mix_columns_f, and RK_ZERO.
//  One sub-module, aes_enc_round (combinational).
//   Inputs: state, round key, final flag. Output: next state.
//   This core keeps only the FSM, the round counter and the state register.
// TESTING
//  FIPS-197 App.B:
//   pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, bench-served key schedule.
//   Expect o_data = 3925841d02dc09fbdc118597196a0b32 exactly 11 clocks after accept.
//  FIPS-197 C.1:
//   pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
//   Expect o_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
//  Backpressure:
//   Hold i_ready=0 for 5 clocks in DONE -> o_valid and o_data stay stable.
//   o_ready stays 0, and an i_valid pulse in that window is dropped.
//  Back-to-back:
//   Two blocks with i_valid held high and i_ready=1 -> second accept 12 clocks after the first.
//   Both ciphertexts correct.
//  Reset mid-operation:
//   Pull n_rst low at round 5 -> next edge shows o_valid=0, o_ready=1, o_data=0, o_rk_idx=0.
//   The next block encrypts correctly.
//  Round-key indexing:
//   Log o_rk_idx per cycle -> sequence 0,1,...,10 with one index per clock.
//   Each index is held exactly one cycle.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types, S-box table and GF(2^8) helpers for the
//                iterative AES encryption core.
//  Contents    : state_t (128-bit block), fsm_t (core FSM encoding),
//                SBOX, RK_ZERO, xtime, shift_rows_f, mix_columns_f.
//  Byte order  : byte0 = [127:120]; state s[r][c] = byte(4c+r).
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   typedef logic [127:0] state_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2,
      S_DONE  = 2'd3
   } fsm_t;

   localparam state_t RK_ZERO = '0;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Row r rotates left by r: out s[r][c] = in s[r][(c+r) mod 4].
   function automatic state_t shift_rows_f(input state_t s);
      state_t o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   // Each column a0..a3 is multiplied by the circulant {02,03,01,01}.
   function automatic state_t mix_columns_f(input state_t s);
      state_t     o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_enc_round.sv
`default_nettype none
// ============================================================================
//  Module      : aes_enc_round
//  Description : One combinational AES encryption round:
//                SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey.
//  Ports       : state_in    - current 128-bit state
//                round_key   - round key to add
//                final_round - high skips MixColumns
//                state_out   - next 128-bit state
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_enc_round
   import aes_pkg::*;
(
   input  state_t state_in,
   input  state_t round_key,
   input  logic   final_round,
   output state_t state_out
);

   state_t sub_bytes;
   state_t shifted;
   state_t mixed;

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      assign sub_bytes[127-8*i -: 8] = SBOX[state_in[127-8*i -: 8]];
   end

   assign shifted   = shift_rows_f(sub_bytes);
   assign mixed     = mix_columns_f(shifted);
   assign state_out = (final_round ? shifted : mixed) ^ round_key;

endmodule
`default_nettype wire

// File: rtl/aes_enc_core.sv
`default_nettype none
// ============================================================================
//  Module      : aes_enc_core
//  Description : Iterative AES encryption engine, one round per clock.
//                Round keys come from an external key schedule by index.
//  Ports       : clk, n_rst (async, active-low)
//                i_valid/o_ready/i_data     - plaintext input handshake
//                o_rk_idx/i_rk_data          - round-key request/response
//                o_valid/i_ready/o_data      - ciphertext output handshake
//                o_busy                      - block in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_enc_core
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int RKIDX_W    = 4
)(
   input  logic               clk,
   input  logic               n_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [127:0]       i_data,
   output logic [RKIDX_W-1:0] o_rk_idx,
   input  logic [127:0]       i_rk_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [127:0]       o_data,
   output logic               o_busy
);

   localparam logic [RKIDX_W-1:0] RND_ONE   = RKIDX_W'(1);
   localparam logic [RKIDX_W-1:0] LAST_MAIN = RKIDX_W'(NUM_ROUNDS - 1);
   localparam logic [RKIDX_W-1:0] LAST_IDX  = RKIDX_W'(NUM_ROUNDS);

   fsm_t               fsm, fsm_nxt;
   logic [RKIDX_W-1:0] rnd, rnd_nxt;
   logic [RKIDX_W-1:0] rk_idx, rk_idx_nxt;
   state_t             state, state_nxt;
   state_t             round_out;

   aes_enc_round u_round (
      .state_in    (state),
      .round_key   (i_rk_data),
      .final_round (fsm == S_FINAL),
      .state_out   (round_out)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         fsm    <= S_IDLE;
         rnd    <= '0;
         rk_idx <= '0;
         state  <= RK_ZERO;
      end else begin
         fsm    <= fsm_nxt;
         rnd    <= rnd_nxt;
         rk_idx <= rk_idx_nxt;
         state  <= state_nxt;
      end
   end

   // rk_idx is registered one step ahead so that the index presented in
   // each cycle is exactly the key that cycle's round consumes.
   always_comb begin
      fsm_nxt    = fsm;
      rnd_nxt    = rnd;
      rk_idx_nxt = rk_idx;
      state_nxt  = state;
      case (fsm)
         S_IDLE: begin
            if (i_valid) begin
               state_nxt = i_data ^ i_rk_data;
               rnd_nxt   = RND_ONE;
               if (NUM_ROUNDS == 1) begin
                  fsm_nxt    = S_FINAL;
                  rk_idx_nxt = LAST_IDX;
               end else begin
                  fsm_nxt    = S_ROUND;
                  rk_idx_nxt = RND_ONE;
               end
            end
         end
         S_ROUND: begin
            state_nxt = round_out;
            rnd_nxt   = rnd + RND_ONE;
            if (rnd == LAST_MAIN) begin
               fsm_nxt    = S_FINAL;
               rk_idx_nxt = LAST_IDX;
            end else begin
               rk_idx_nxt = rnd + RND_ONE;
            end
         end
         S_FINAL: begin
            state_nxt  = round_out;
            rnd_nxt    = '0;
            rk_idx_nxt = '0;
            fsm_nxt    = S_DONE;
         end
         S_DONE: begin
            if (i_ready) begin
               fsm_nxt = S_IDLE;
            end
         end
         default: begin
            fsm_nxt = S_IDLE;
         end
      endcase
   end

   assign o_ready  = (fsm == S_IDLE);
   assign o_valid  = (fsm == S_DONE);
   assign o_busy   = (fsm != S_IDLE);
   assign o_data   = state;
   assign o_rk_idx = rk_idx;

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_enc_core
//  Description : Directed bench for aes_enc_core using FIPS-197 vectors,
//                with a bench-side key schedule serving round keys by index.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_enc_core;

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         i_valid;
   logic         o_ready;
   logic [127:0] i_data;
   logic [3:0]   o_rk_idx;
   logic [127:0] i_rk_data;
   logic         o_valid;
   logic         i_ready;
   logic [127:0] o_data;
   logic         o_busy;

   logic [127:0] rks [2][11];
   logic         ksel;
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   aes_enc_core #(.NUM_ROUNDS(10), .RKIDX_W(4)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_data    (i_data),
      .o_rk_idx  (o_rk_idx),
      .i_rk_data (i_rk_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_data    (o_data),
      .o_busy    (o_busy)
   );

   // Key schedule responds combinationally to the requested index.
   always_comb begin
      i_rk_data = '0;
      if (o_rk_idx <= 4'd10) i_rk_data = rks[ksel][o_rk_idx];
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Independent S-box: multiplicative inverse then affine transform.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   task automatic expand(input logic [127:0] key, input int ks);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rks[ks][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Single block: checks index sequence, latency, result, and optional
   // backpressure window with a stray i_valid pulse.
   task automatic run_block(input logic [127:0] pt, input logic ks, input logic [127:0] exp,
                            input int hold, input bit pulse);
      int n;
      bit seen;
      @(negedge clk);
      ksel    = ks;
      i_ready = 1'b0;
      check_eq("idle_ready", 128'(o_ready), 128'd1);
      check_eq("idx_accept", 128'(o_rk_idx), 128'd0);
      i_valid = 1'b1;
      i_data  = pt;
      @(negedge clk);
      i_valid = 1'b0;
      i_data  = {$urandom, $urandom, $urandom, $urandom};
      n    = 1;
      seen = 1'b0;
      while (n < 40 && !seen) begin
         if (o_valid) begin
            seen = 1'b1;
         end else begin
            if (n <= 10) check_eq("rk_idx", 128'(o_rk_idx), 128'(n));
            n++;
            @(negedge clk);
         end
      end
      check_eq("valid_seen", 128'(seen), 128'd1);
      check_eq("latency", 128'(n), 128'd11);
      check_eq("ciphertext", o_data, exp);
      check_eq("busy_done", 128'(o_busy), 128'd1);
      for (int h = 0; h < hold; h++) begin
         check_eq("hold_valid", 128'(o_valid), 128'd1);
         check_eq("hold_data", o_data, exp);
         check_eq("hold_ready", 128'(o_ready), 128'd0);
         i_valid = pulse && (h == 1);
         i_data  = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      check_eq("post_valid", 128'(o_valid), 128'd0);
      check_eq("post_ready", 128'(o_ready), 128'd1);
      check_eq("post_busy", 128'(o_busy), 128'd0);
   endtask

   task automatic back_to_back();
      int acc [2];
      int outc [2];
      logic [127:0] outd [2];
      int nacc = 0;
      int nout = 0;
      acc  = '{-100, 0};
      outc = '{0, 0};
      outd = '{128'h0, 128'h0};
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = PT_B;
      ksel    = 1'b0;
      i_ready = 1'b1;
      for (int c = 0; c < 60 && nout < 2; c++) begin
         if (o_ready && i_valid) begin
            if (nacc < 2) acc[nacc] = c;
            nacc++;
         end else if (nacc >= 2) begin
            i_valid = 1'b0;
         end
         if (o_valid) begin
            outd[nout] = o_data;
            outc[nout] = c;
            nout++;
            i_data = PT_C;
            ksel   = 1'b1;
         end
         @(negedge clk);
      end
      i_valid = 1'b0;
      i_ready = 1'b0;
      check_eq("b2b_outputs", 128'(nout), 128'd2);
      check_eq("b2b_spacing", 128'(acc[1] - acc[0]), 128'd12);
      check_eq("b2b_latency", 128'(outc[0] - acc[0]), 128'd11);
      check_eq("b2b_ct0", outd[0], CT_B);
      check_eq("b2b_ct1", outd[1], CT_C);
   endtask

   task automatic reset_mid();
      @(negedge clk);
      ksel    = 1'b0;
      i_valid = 1'b1;
      i_data  = PT_B;
      @(negedge clk);
      i_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("idx_round5", 128'(o_rk_idx), 128'd5);
      n_rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_valid", 128'(o_valid), 128'd0);
      check_eq("rst_ready", 128'(o_ready), 128'd1);
      check_eq("rst_data", o_data, 128'd0);
      check_eq("rst_idx", 128'(o_rk_idx), 128'd0);
      check_eq("rst_busy", 128'(o_busy), 128'd0);
      @(negedge clk);
      n_rst = 1'b1;
      run_block(PT_C, 1'b1, CT_C, 0, 1'b0);
   endtask

   initial begin
      n_rst   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      i_ready = 1'b0;
      ksel    = 1'b0;
      expand(KEY_B, 0);
      expand(KEY_C, 1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_ready", 128'(o_ready), 128'd1);
      check_eq("reset_valid", 128'(o_valid), 128'd0);
      check_eq("reset_busy", 128'(o_busy), 128'd0);
      check_eq("reset_data", o_data, 128'd0);
      check_eq("reset_idx", 128'(o_rk_idx), 128'd0);
      @(negedge clk);
      n_rst = 1'b1;

      run_block(PT_B, 1'b0, CT_B, 5, 1'b1);
      run_block(PT_C, 1'b1, CT_C, 0, 1'b0);
      back_to_back();
      reset_mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
